// File: rtl/fifo_drain.sv
// fifo_drain: pops one word at a time from the FIFO read port and holds it
// on a valid/ready output. Optional counter macro: FIFO_DRAIN_COUNT_EN.
module fifo_drain #(
  parameter int width = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             fifo_empty,
  output logic             fifo_read,
  input  logic [width-1:0] fifo_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] out_data,
  output logic             busy,
  output logic [7:0]       drained_count
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WAIT,
    VALID
  } state_t;

  state_t state;

  logic can_pop;
  logic accept;

  assign can_pop = enable & ~fifo_empty;
  assign accept  = out_valid & out_ready;

  // Pop/capture/present sequencer; every output is a register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      fifo_read <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (can_pop) begin
            state     <= READ;
            fifo_read <= 1'b1;
            busy      <= 1'b1;
          end
        end
        READ: begin
          state     <= WAIT;
          fifo_read <= 1'b0;
        end
        WAIT: begin
          state     <= VALID;
          out_data  <= fifo_data;
          out_valid <= 1'b1;
        end
        VALID: begin
          if (accept) begin
            out_valid <= 1'b0;
            if (can_pop) begin
              state     <= READ;
              fifo_read <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state     <= IDLE;
          fifo_read <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef FIFO_DRAIN_COUNT_EN
  logic [7:0] cnt;

  // Count accepted words; wraps naturally at 8 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= 8'd0;
    end else if (accept) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign drained_count = cnt;
`else
  assign drained_count = 8'd0;
`endif

endmodule

// File: tb/tb_fifo_drain.sv
// tb_fifo_drain: FIFO model + scoreboard + vector table for fifo_drain.
// Expectations for drained_count follow FIFO_DRAIN_COUNT_EN.
module tb_fifo_drain;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       fifo_empty = 1'b1;
  logic       fifo_read;
  logic [3:0] fifo_data = 4'h0;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       busy;
  logic [7:0] drained_count;

  int errors = 0;
  int checks = 0;

  logic [3:0] fq[$];
  logic [3:0] exp_q[$];

  int nacc  = 0;
  int reads = 0;
  int cyc   = 0;
  int last_hs = 0;
  bit have_last = 0;
  bit prev_rd = 0;
  int mcnt = 0;

  typedef struct {
    logic [3:0] data;
    int         stall;
  } vec_t;

  vec_t vt[4];

  fifo_drain #(.width(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .fifo_empty    (fifo_empty),
    .fifo_read     (fifo_read),
    .fifo_data     (fifo_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .busy          (busy),
    .drained_count (drained_count)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  // FIFO read port: word popped in cycle N appears in cycle N+1
  always @(posedge clk) begin
    if (fifo_read && fq.size() > 0) fifo_data <= fq.pop_front();
  end

  always @(negedge clk) begin
    fifo_empty <= (fq.size() == 0);
  end

  // Monitor: pop rules, scoreboard, handshake spacing, count model
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      mcnt = 0;
      have_last = 0;
      prev_rd = 0;
    end else begin
      if (fifo_read) begin
        reads++;
        chk("read_while_empty", {31'd0, fifo_empty}, 32'd0);
        chk("read_back_to_back", {31'd0, prev_rd}, 32'd0);
      end
      prev_rd = fifo_read;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          chk("sb_data", {28'd0, out_data}, {28'd0, exp_q.pop_front()});
        end
        if (have_last) chk("hs_gap_ge3", {31'd0, (cyc - last_hs) >= 3}, 32'd1);
        have_last = 1;
        last_hs = cyc;
        nacc++;
`ifdef FIFO_DRAIN_COUNT_EN
        mcnt = (mcnt + 1) % 256;
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(logic [3:0] w);
    fq.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic wait_read(string nm);
    int n = 0;
    while (!fifo_read && n < 20) begin
      tick();
      n++;
    end
    chk(nm, {31'd0, fifo_read}, 32'd1);
  endtask

  task automatic wait_idle(string nm);
    int n = 0;
    while (busy && n < 60) begin
      tick();
      n++;
    end
    chk(nm, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_acc(string nm, int target, int budget);
    int n = 0;
    while (nacc < target && n < budget) begin
      tick();
      n++;
    end
    chk(nm, nacc, target);
  endtask

  initial begin
    int r0;
    int n0;
    int n;
    bit stable;
    logic [3:0] d0;

    vt[0] = '{4'h1, 0};
    vt[1] = '{4'hF, 2};
    vt[2] = '{4'h0, 5};
    vt[3] = '{4'h8, 1};

    reset = 1'b1;
    enable = 1'b1;
    out_ready = 1'b0;

    // reset while idle with a non-empty FIFO
    push(4'h9);
    repeat (3) tick();
    chk("rst_fifo_read", {31'd0, fifo_read}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {28'd0, out_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_count", {24'd0, drained_count}, 32'd0);
    reset = 1'b0;
    tick();
    chk("rst_release_read", {31'd0, fifo_read}, 32'd1);
    out_ready = 1'b1;
    wait_acc("rst_word", 1, 10);
    wait_idle("rst_idle");

    // single word with consumer always ready
    r0 = reads;
    push(4'hA);
    wait_read("single_read");
    tick();
    chk("single_wait_nvalid", {31'd0, out_valid}, 32'd0);
    tick();
    chk("single_valid", {31'd0, out_valid}, 32'd1);
    chk("single_data", {28'd0, out_data}, 32'd10);
    tick();
    chk("single_valid_1cyc", {31'd0, out_valid}, 32'd0);
    repeat (5) tick();
    chk("single_one_pop", reads - r0, 32'd1);
    chk("single_hold_data", {28'd0, out_data}, 32'd10);

    // vector table: latency, hold under stall, release
    for (int i = 0; i < 4; i++) begin
      out_ready = 1'b0;
      n0 = nacc;
      push(vt[i].data);
      wait_read($sformatf("vec%0d_read", i));
      tick();
      chk($sformatf("vec%0d_wait", i), {31'd0, out_valid}, 32'd0);
      tick();
      chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
      repeat (vt[i].stall) tick();
      chk($sformatf("vec%0d_data", i), {28'd0, out_data}, {28'd0, vt[i].data});
      chk($sformatf("vec%0d_held", i), {31'd0, out_valid}, 32'd1);
      out_ready = 1'b1;
      tick();
      chk($sformatf("vec%0d_acc", i), nacc - n0, 32'd1);
      chk($sformatf("vec%0d_drop", i), {31'd0, out_valid}, 32'd0);
      wait_idle($sformatf("vec%0d_idle", i));
    end

    // backpressure: 10-cycle stall on the first of three words
    out_ready = 1'b0;
    r0 = reads;
    n0 = nacc;
    push(4'h3);
    push(4'h5);
    push(4'h7);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk("bp_valid", {31'd0, out_valid}, 32'd1);
    d0 = out_data;
    stable = 1;
    repeat (10) begin
      tick();
      if (out_data !== d0 || !out_valid) stable = 0;
    end
    chk("bp_stable", {31'd0, stable}, 32'd1);
    chk("bp_first", {28'd0, out_data}, 32'd3);
    chk("bp_one_read", reads - r0, 32'd1);
    out_ready = 1'b1;
    wait_acc("bp_all", n0 + 3, 40);
    wait_idle("bp_idle");
    tick();
    chk("bp_count", {24'd0, drained_count}, mcnt);

    // enable drop during WAIT
    out_ready = 1'b0;
    n0 = nacc;
    push(4'hC);
    push(4'hD);
    wait_read("en_read");
    tick();
    enable = 1'b0;
    tick();
    chk("en_valid", {31'd0, out_valid}, 32'd1);
    chk("en_data", {28'd0, out_data}, 32'd12);
    out_ready = 1'b1;
    tick();
    chk("en_acc", nacc - n0, 32'd1);
    r0 = reads;
    repeat (6) tick();
    chk("en_no_pop", reads - r0, 32'd0);
    chk("en_not_busy", {31'd0, busy}, 32'd0);
    enable = 1'b1;
    wait_acc("en_resume", n0 + 2, 20);
    wait_idle("en_idle");

    // asynchronous reset while in WAIT
    out_ready = 1'b1;
    n0 = nacc;
    push(4'h6);
    wait_read("ar_read");
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk("ar_valid", {31'd0, out_valid}, 32'd0);
    chk("ar_busy", {31'd0, busy}, 32'd0);
    chk("ar_read", {31'd0, fifo_read}, 32'd0);
    void'(exp_q.pop_back());
    tick();
    reset = 1'b0;
    repeat (6) tick();
    chk("ar_never_shown", nacc - n0, 32'd0);
    chk("ar_out_data", {28'd0, out_data}, 32'd0);
    chk("ar_idle", {31'd0, busy}, 32'd0);

    // counter wrap: 257 accepted words from a fresh reset
    n0 = nacc;
    for (int i = 0; i < 257; i++) push(i[3:0]);
    wait_acc("wrap_words", n0 + 257, 1500);
    wait_idle("wrap_idle");
    tick();
    chk("wrap_model", {24'd0, drained_count}, mcnt);
`ifdef FIFO_DRAIN_COUNT_EN
    chk("wrap_count", {24'd0, drained_count}, 32'd1);
`else
    chk("wrap_count", {24'd0, drained_count}, 32'd0);
`endif

    chk("sb_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
